// File: rtl/spio_hss_multiplexer_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : spio_hss_multiplexer_tx_scheduler
//  Brief    : HSS TX scheduler - round-robin channel slotting into data frames,
//             frame open/close control and ack/nak frame insertion.
//  Revision : 1.0 - initial release
// ============================================================================
module spio_hss_multiplexer_tx_scheduler #(
   parameter int NUM_CHANS    = 8,
   parameter int FILL_TIMEOUT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CHANS-1:0] ch_req,
   input  logic [NUM_CHANS-1:0] cfc_rem,
   input  logic                 credit_avail,
   input  logic                 ack_rts,
   input  logic                 asm_rdy,
   output logic [NUM_CHANS-1:0] ch_gnt,
   output logic                 frm_start,
   output logic                 frm_close,
   output logic                 ack_gnt,
   output logic [NUM_CHANS-1:0] frm_chans,
   output logic                 sch_busy
);

   localparam int         c_pw      = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1;
   localparam int         c_pw1     = c_pw + 1;
   localparam logic [3:0] c_pkt_max = 4'(NUM_CHANS);
   localparam logic [3:0] c_timeout = 4'(FILL_TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_CLOSE = 2'd2
   } state_t;

   state_t                 r_state;
   logic [c_pw-1:0]        r_rr_ptr;
   logic [NUM_CHANS-1:0]   r_frm_chans;
   logic [3:0]             r_pkt_cnt;
   logic [3:0]             r_idle_cnt;

   logic [NUM_CHANS-1:0]   w_elig;
   logic [2*NUM_CHANS-1:0] w_dbl;
   logic [NUM_CHANS-1:0]   w_rot;
   logic                   w_found;
   logic [c_pw1-1:0]       w_sum;
   logic [c_pw-1:0]        w_win;
   logic [c_pw-1:0]        w_rr_next;
   logic [NUM_CHANS-1:0]   w_win_oh;
   logic                   w_act;
   logic                   w_do_ack;
   logic                   w_do_start;
   logic                   w_do_grant;
   logic                   w_do_close;
   logic [3:0]             w_pkt_inc;
   logic [3:0]             w_idle_inc;

   assign w_elig = ch_req & cfc_rem & ~r_frm_chans;

   // Rotate eligibility so bit 0 is the channel at rr_ptr; first set bit wins.
   assign w_dbl = {w_elig, w_elig} >> r_rr_ptr;
   assign w_rot = w_dbl[NUM_CHANS-1:0];

   always_comb begin
      w_found = 1'b0;
      w_sum   = '0;
      w_win   = '0;
      for (int k = 0; k < NUM_CHANS; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_sum   = {1'b0, r_rr_ptr} + c_pw1'(k);
            w_win   = (w_sum >= c_pw1'(NUM_CHANS)) ? c_pw'(w_sum - c_pw1'(NUM_CHANS))
                                                   : c_pw'(w_sum);
         end
      end
   end

   assign w_rr_next = (w_win == c_pw'(NUM_CHANS - 1)) ? '0 : w_win + c_pw'(1);
   assign w_win_oh  = {{(NUM_CHANS-1){1'b0}}, 1'b1} << w_win;

   assign w_act      = !rst && asm_rdy;
   assign w_do_ack   = w_act && (r_state == S_IDLE) && ack_rts;
   assign w_do_start = w_act && (r_state == S_IDLE) && !ack_rts && credit_avail && w_found;
   assign w_do_grant = w_do_start || (w_act && (r_state == S_FILL) && w_found);
   assign w_do_close = w_act && (r_state == S_CLOSE);

   assign ch_gnt    = w_do_grant ? w_win_oh : '0;
   assign frm_start = w_do_start;
   assign frm_close = w_do_close;
   assign ack_gnt   = w_do_ack;
   assign frm_chans = r_frm_chans;
   assign sch_busy  = (r_state != S_IDLE);

   assign w_pkt_inc  = r_pkt_cnt + 4'd1;
   assign w_idle_inc = r_idle_cnt + 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_frm_chans <= '0;
         r_pkt_cnt   <= '0;
         r_idle_cnt  <= '0;
      end else if (asm_rdy) begin
         case (r_state)
            S_IDLE: begin
               if (w_do_start) begin
                  r_frm_chans <= w_win_oh;
                  r_pkt_cnt   <= 4'd1;
                  r_idle_cnt  <= '0;
                  r_rr_ptr    <= w_rr_next;
                  r_state     <= S_FILL;
               end
            end
            S_FILL: begin
               if (w_found) begin
                  r_frm_chans <= r_frm_chans | w_win_oh;
                  r_pkt_cnt   <= w_pkt_inc;
                  r_idle_cnt  <= '0;
                  r_rr_ptr    <= w_rr_next;
                  if (w_pkt_inc == c_pkt_max) r_state <= S_CLOSE;
               end else begin
                  r_idle_cnt <= w_idle_inc;
                  if (w_idle_inc == c_timeout) r_state <= S_CLOSE;
               end
            end
            S_CLOSE: begin
               r_frm_chans <= '0;
               r_pkt_cnt   <= '0;
               r_idle_cnt  <= '0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spio_hss_multiplexer_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spio_hss_multiplexer_tx_scheduler
//  Brief    : Directed self-checking bench for the HSS TX scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spio_hss_multiplexer_tx_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ch_req;
   logic [7:0] cfc_rem;
   logic       credit_avail;
   logic       ack_rts;
   logic       asm_rdy;
   logic [7:0] ch_gnt;
   logic       frm_start;
   logic       frm_close;
   logic       ack_gnt;
   logic [7:0] frm_chans;
   logic       sch_busy;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   spio_hss_multiplexer_tx_scheduler #(.NUM_CHANS(8), .FILL_TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .ch_req       (ch_req),
      .cfc_rem      (cfc_rem),
      .credit_avail (credit_avail),
      .ack_rts      (ack_rts),
      .asm_rdy      (asm_rdy),
      .ch_gnt       (ch_gnt),
      .frm_start    (frm_start),
      .frm_close    (frm_close),
      .ack_gnt      (ack_gnt),
      .frm_chans    (frm_chans),
      .sch_busy     (sch_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Check one cycle's pulses {start,close,ack,gnt}, then advance; granted
   // channels drop their request as the packet is popped.
   task automatic step(input string tag, input logic st, input logic cl,
                       input logic ak, input logic [7:0] gnt);
      logic [7:0] g;
      @(negedge clk);
      chk(tag, {21'd0, frm_start, frm_close, ack_gnt, ch_gnt}, {21'd0, st, cl, ak, gnt});
      g = ch_gnt;
      @(posedge clk); #1;
      ch_req = ch_req & ~g;
   endtask

   initial begin
      logic [7:0] exp_fair [8];
      exp_fair = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};

      // Reset, with requests present: pulses must stay low.
      rst = 1'b1; ch_req = 8'hFF; cfc_rem = 8'hFF; credit_avail = 1'b1;
      ack_rts = 1'b0; asm_rdy = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      step("rst_pulses", 0, 0, 0, 8'h00);
      chk("rst_busy", {31'd0, sch_busy}, 32'd0);
      chk("rst_chans", {24'd0, frm_chans}, 32'd0);

      // Full frame, rr_ptr starts at 0.
      rst = 1'b0; ch_req = 8'hFF;
      for (int i = 0; i < 8; i++) step("full_gnt", i == 0, 0, 0, 8'h01 << i);
      chk("full_chans", {24'd0, frm_chans}, 32'hFF);
      ch_req = 8'h05;
      step("full_close", 0, 1, 0, 8'h00);

      // Partial frame closed by timeout; back-to-back start after close.
      step("part_c0", 1, 0, 0, 8'h01);
      chk("part_chans0", {24'd0, frm_chans}, 32'h01);
      step("part_c1", 0, 0, 0, 8'h04);
      chk("part_chans1", {24'd0, frm_chans}, 32'h05);
      for (int i = 0; i < 4; i++) step("part_idle", 0, 0, 0, 8'h00);
      step("part_close", 0, 1, 0, 8'h00);
      chk("part_chans_clr", {24'd0, frm_chans}, 32'h00);
      chk("part_busy", {31'd0, sch_busy}, 32'd0);

      // Fairness: last grant was ch2, so ch3 leads and ch0 is sixth.
      ch_req = 8'hFF;
      for (int i = 0; i < 8; i++) step("fair_gnt", i == 0, 0, 0, exp_fair[i]);
      step("fair_close", 0, 1, 0, 8'h00);

      // Ack has priority in IDLE.
      ack_rts = 1'b1; ch_req = 8'h01;
      step("ack_idle", 0, 0, 1, 8'h00);
      ack_rts = 1'b0;
      step("ack_then_start", 1, 0, 0, 8'h01);
      // Ack raised mid-frame waits for the close.
      ack_rts = 1'b1;
      for (int i = 0; i < 4; i++) step("ack_fill_wait", 0, 0, 0, 8'h00);
      step("ack_fill_close", 0, 1, 0, 8'h00);
      step("ack_after_close", 0, 0, 1, 8'h00);
      ack_rts = 1'b0;

      // Remote flow control blocks ch0.
      cfc_rem = 8'hFE; ch_req = 8'h03;
      step("cfc_gnt", 1, 0, 0, 8'h02);
      for (int i = 0; i < 4; i++) step("cfc_blocked", 0, 0, 0, 8'h00);
      ch_req = 8'h00; cfc_rem = 8'hFF;
      step("cfc_close", 0, 1, 0, 8'h00);

      // No credit: ack still goes, no frame opens.
      credit_avail = 1'b0; ch_req = 8'hFF; ack_rts = 1'b1;
      step("nocred_ack", 0, 0, 1, 8'h00);
      ack_rts = 1'b0;
      step("nocred_nostart", 0, 0, 0, 8'h00);
      chk("nocred_busy", {31'd0, sch_busy}, 32'd0);
      credit_avail = 1'b1;
      step("cred_start", 1, 0, 0, 8'h04);

      // Stall: asm_rdy low freezes everything, including the idle timer.
      ch_req = 8'h00;
      step("stall_idle1", 0, 0, 0, 8'h00);
      step("stall_idle2", 0, 0, 0, 8'h00);
      asm_rdy = 1'b0; ch_req = 8'hFF; ack_rts = 1'b1;
      for (int i = 0; i < 3; i++) step("stall_quiet", 0, 0, 0, 8'h00);
      chk("stall_chans", {24'd0, frm_chans}, 32'h04);
      chk("stall_busy", {31'd0, sch_busy}, 32'd1);
      asm_rdy = 1'b1; ch_req = 8'h00; ack_rts = 1'b0;
      step("stall_idle3", 0, 0, 0, 8'h00);
      step("stall_idle4", 0, 0, 0, 8'h00);
      step("stall_close", 0, 1, 0, 8'h00);

      // Reset mid-frame abandons it silently.
      ch_req = 8'hFF;
      step("rstmid_start", 1, 0, 0, 8'h08);
      step("rstmid_gnt", 0, 0, 0, 8'h10);
      rst = 1'b1;
      step("rstmid_pulses", 0, 0, 0, 8'h00);
      rst = 1'b0; ch_req = 8'h00;
      @(negedge clk);
      chk("rstmid_busy", {31'd0, sch_busy}, 32'd0);
      chk("rstmid_chans", {24'd0, frm_chans}, 32'h00);
      for (int i = 0; i < 6; i++) step("rstmid_noclose", 0, 0, 0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spio_hss_multiplexer_tx_scheduler.md
Name: spio_hss_multiplexer_tx_scheduler

Overview:
Transmit-side scheduler for the HSS multiplexer. It decides, cycle by cycle, which of the 8 channel packet queues gets the next slot in the data frame being built by the frame assembler. It opens and closes data frames, and inserts ack/nak frames requested by the packet dispatcher. Arbitration is round-robin and is gated by remote channel flow control and by frame credit.

Parameters:
NUM_CHANS, 8, number of packet channels; also the maximum packets per frame (one per channel).
FILL_TIMEOUT, 4, number of consecutive asm_rdy cycles without a grant after which a partially filled frame is closed (legal range 1..15).

Ports:
clk  input  1  system clock; the block's only clock.
rst  input  1  synchronous, active-high reset.
ch_req  input  NUM_CHANS  channel i has a packet pending; held high until granted.
cfc_rem  input  NUM_CHANS  remote channel flow control; 1 = channel i may send.
credit_avail  input  1  the outstanding-frame window has room for a new data frame.
ack_rts  input  1  the dispatcher has an ack/nak to send; level, held until ack_gnt.
asm_rdy  input  1  the frame assembler accepts a command this cycle.
ch_gnt  output  NUM_CHANS  one-hot pulse: pop channel i's packet into the current frame slot.
frm_start  output  1  pulse: open a new data frame.
frm_close  output  1  pulse: seal and transmit the current data frame.
ack_gnt  output  1  pulse: assembler sends an ack/nak frame now.
frm_chans  output  NUM_CHANS  registered mask of the channels already placed in the current frame.
sch_busy  output  1  1 when state != IDLE.

Behaviour:
- State register: IDLE, FILL, CLOSE. Registered state: rr_ptr (3b), frm_chans, pkt_cnt (4b), idle_cnt (4b).
- Outputs are a combinational decode of the registered state and the current inputs (grant in the same cycle as the request).
- All pulse outputs are forced to 0 while rst=1.
- Reset (sync): state=IDLE, rr_ptr=0, frm_chans=0, pkt_cnt=0, idle_cnt=0. All outputs 0.
- Reset mid-frame abandons the frame; no frm_close is emitted.
- elig = ch_req & cfc_rem & ~frm_chans.
- Round-robin winner: the first set bit of elig searching upward from rr_ptr, wrapping at NUM_CHANS-1 to 0. After granting channel i, rr_ptr <= (i+1) mod NUM_CHANS.
- Nothing happens in any cycle with asm_rdy=0: no pulses, no counter or state change.
- IDLE (asm_rdy=1):
  - ack_rts=1 has top priority: ack_gnt=1 for one cycle, stay IDLE. It ignores credit_avail.
  - Else, if credit_avail=1 and elig!=0: frm_start=1 and ch_gnt=winner in the same cycle. Set the winner's bit in frm_chans, pkt_cnt=1, idle_cnt=0, go to FILL.
  - Else stay IDLE.
- FILL (asm_rdy=1):
  - If elig!=0: grant the winner, set its frm_chans bit, pkt_cnt+1, idle_cnt=0. If pkt_cnt reaches NUM_CHANS, go to CLOSE.
  - If elig=0: idle_cnt+1. When the new idle_cnt equals FILL_TIMEOUT, go to CLOSE.
  - ack_rts does not preempt a frame; it waits until the frame is closed.
  - Loss of credit_avail during FILL does not stop the frame.
- CLOSE (asm_rdy=1): frm_close=1. Clear frm_chans, pkt_cnt and idle_cnt, go to IDLE. No grant, ack or start in this cycle.
- cfc_rem dropping mid-frame only makes that channel ineligible. No packet is dropped.
- A channel never appears twice in a frame (masked by frm_chans).
- At most one bit of ch_gnt is set in any cycle.
- frm_start and frm_close never occur in the same cycle.
- Minimum gap between frames is one cycle (the CLOSE cycle). A back-to-back frame_start is possible in the cycle after CLOSE.

Test Plan:
1. After reset: ch_req=0x05, cfc_rem=0xFF, credit_avail=1, asm_rdy=1.
   - c0: frm_start=1, ch_gnt=0x01. c1: ch_gnt=0x04. c2..c5: idle. c6: frm_close=1.
   - frm_chans: 0x01 after c0, 0x05 after c1, 0x00 after c6.
2. ch_req=0xFF held, all enables set.
   - Grants 0x01,0x02,...,0x80 on c0..c7; frm_close on c8 (full frame, no timeout wait); frm_start again on c9.
3. Fairness: frame ends with last grant ch2 (rr_ptr=3); next frame with ch_req=0xFF.
   - First ch_gnt=0x08; ch0 is granted 6th.
4. Ack scheduling:
   - ack_rts=1 and ch_req=0x01 in IDLE: ack_gnt c0, frm_start+ch_gnt=0x01 c1.
   - ack_rts raised in FILL: ack_gnt only in the cycle after frm_close.
5. Gating:
   - cfc_rem=0xFE, ch_req=0x03: only ch_gnt=0x02 issued.
   - credit_avail=0, ch_req=0xFF, ack_rts=1: ack_gnt=1, no frm_start.
6. Stall and reset:
   - asm_rdy=0 for 3 cycles during FILL: no pulses, idle_cnt frozen; timeout resumes counting when asm_rdy returns.
   - rst=1 mid-FILL: all pulses 0 that cycle; next cycle sch_busy=0, frm_chans=0, no frm_close ever emitted.
